inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of queue entries; power of two, at least 4.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports: in1_valid/in2_valid  in  1  decode slot 1/2 holds an instruction; slot 1 is older.
REQ-005 SHALL have ports: in1_pc/in2_pc, in1_npc/in2_npc  in  PC_BUS  PC and next PC per slot.
REQ-006 SHALL have ports: in1_decodeout/in2_decodeout  in  DECODEOUT_BUS  decoded fields per slot.
REQ-007 SHALL have port: in_ready  out  1  queue can accept two entries this cycle.
REQ-008 SHALL have port: flush  in  1  discard all queued entries (redirect).
REQ-009 SHALL have port: launch_flag  in  4  issue result from the launch stage; [3]/[2] = inst1 issued, [1]/[0] = inst2 issued.
REQ-010 SHALL have ports: out1_pc, out1_npc, out1_decodeout, receive_flag1  out  PC_BUS/PC_BUS/DECODEOUT_BUS/1  oldest entry.
REQ-011 SHALL have ports: out2_pc, out2_npc, out2_decodeout, receive_flag2  out  PC_BUS/PC_BUS/DECODEOUT_BUS/1  second-oldest entry.
REQ-012 SHALL have port: occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-013 SHALL implement a circular FIFO with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-014 SHALL drive in_ready = (DEPTH - count >= 2), using the registered count; same-cycle pops are not credited.
REQ-015 SHALL push only when in_ready=1: both slots valid -> 2 entries, slot 1 first; exactly one slot valid -> that slot's entry only.
REQ-016 SHALL ignore in*_valid when in_ready=0; upstream holds data until in_ready=1.
REQ-017 SHALL derive issued1 = launch_flag[3]|launch_flag[2] and issued2 = launch_flag[1]|launch_flag[0].
REQ-018 SHALL pop issued1 + (issued1 & issued2) entries; issued2 without issued1 pops 0 entries.
REQ-019 SHALL never pop more than count; a pop request on an invalid output entry is ignored.
REQ-020 SHALL support push and pop in the same cycle: count_next = count + pushes - pops.
REQ-021 SHALL make a pushed entry visible on out1/out2 at the cycle after the push (latency 1).
REQ-022 SHALL compute out1/out2 combinationally from the registered queue state; receive_flag1 = count>=1 and receive_flag2 = count>=2.
REQ-023 SHALL drive an invalid output slot with PC_INITIAL, NPC_INITIAL and DC_INITIAL.
REQ-024 SHALL, on flush, reset pointers and count to 0 at the next edge; flush has priority over same-cycle push and pop.

Reset
REQ-025 SHALL, while rst=1, hold pointers and count at 0, receive_flag1/2 at 0, in_ready at 1 and occupancy at 0.
REQ-026 SHALL drop all entries when rst is asserted mid-operation; entry storage contents need not be cleared.

Configuration
REQ-027 SHALL support macro IQ_BYPASS_EN; when defined and count=0 (and flush=0), valid inputs appear on out1/out2 in the same cycle.
REQ-028 SHALL, with IQ_BYPASS_EN defined, push only the bypassed entries that were not popped by the same-cycle launch_flag.
REQ-029 SHALL, without IQ_BYPASS_EN, have no combinational path from in* to out* or receive_flag*.

Structure
REQ-030 SHALL take PC_BUS, DECODEOUT_BUS, PC_INITIAL, NPC_INITIAL and DC_INITIAL from def.vh, and add IQ_ENTRY_W (pc+npc+decodeout width) there.
REQ-031 SHALL place entry storage in one sub-module, iq_ram: DEPTH x IQ_ENTRY_W, 2 write ports, 2 asynchronous read ports, no reset.

Verification
REQ-032 SHALL cover: reset, then push two entries (pc 0x100 and 0x104) -> the next cycle receive_flag1/2=1, out1_pc=0x100, out2_pc=0x104.
REQ-033 SHALL cover: count=2, launch_flag=4'b1000 -> the next cycle out1_pc=0x104, receive_flag2=0, occupancy=1.
REQ-034 SHALL cover: fill to count=7 (DEPTH 8) -> in_ready=0; a push attempt is ignored and occupancy stays 7.
REQ-035 SHALL cover: 20 cycles of 2-push/2-pop with incrementing PCs -> output order is preserved across pointer wrap.
REQ-036 SHALL cover: count=5 with flush=1, push and launch_flag=4'b1001 in the same cycle -> the next cycle occupancy=0, receive_flag1=0.
REQ-037 SHALL cover: launch_flag=4'b0001 with count=2 -> no pop, and occupancy stays 2.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Types and helpers shared by the instruction queue, its interface and its storage.
`include "def.vh"

package inst_queue_pkg;

  typedef logic [`PC_BUS]        pc_t;
  typedef logic [`DECODEOUT_BUS] dc_t;

  typedef struct packed {
    pc_t pc;
    pc_t npc;
    dc_t dc;
  } iq_entry_t;

  // What an output slot shows when it holds no instruction.
  localparam iq_entry_t ENTRY_INIT = '{pc: `PC_INITIAL, npc: `NPC_INITIAL, dc: `DC_INITIAL};

  // Entries retired by the launch stage: inst2 can only leave together with inst1.
  function automatic logic [1:0] pop_request(input logic [3:0] launch_flag);
    logic issued1;
    logic issued2;
    issued1 = launch_flag[3] | launch_flag[2];
    issued2 = launch_flag[1] | launch_flag[0];
    if (issued1 && issued2) begin
      return 2'd2;
    end else if (issued1) begin
      return 2'd1;
    end
    return 2'd0;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Decode-to-queue and queue-to-launch signals of the instruction queue.
// master = decode/launch side, slave = the queue itself.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) ();

  logic                     in1_valid;
  logic                     in2_valid;
  pc_t                      in1_pc;
  pc_t                      in2_pc;
  pc_t                      in1_npc;
  pc_t                      in2_npc;
  dc_t                      in1_decodeout;
  dc_t                      in2_decodeout;
  logic                     in_ready;
  logic                     flush;
  logic [3:0]               launch_flag;
  pc_t                      out1_pc;
  pc_t                      out1_npc;
  dc_t                      out1_decodeout;
  logic                     receive_flag1;
  pc_t                      out2_pc;
  pc_t                      out2_npc;
  dc_t                      out2_decodeout;
  logic                     receive_flag2;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output in1_valid, in2_valid, in1_pc, in2_pc, in1_npc, in2_npc,
           in1_decodeout, in2_decodeout, flush, launch_flag,
    input  in_ready, out1_pc, out1_npc, out1_decodeout, receive_flag1,
           out2_pc, out2_npc, out2_decodeout, receive_flag2, occupancy
  );

  modport slave (
    input  in1_valid, in2_valid, in1_pc, in2_pc, in1_npc, in2_npc,
           in1_decodeout, in2_decodeout, flush, launch_flag,
    output in_ready, out1_pc, out1_npc, out1_decodeout, receive_flag1,
           out2_pc, out2_npc, out2_decodeout, receive_flag2, occupancy
  );

endinterface

// File: rtl/def.vh
// Shared bus widths and idle values for the instruction path.
// IQ_ENTRY_W is the packed width of one queue entry: pc + npc + decodeout.
`ifndef DEF_VH
`define DEF_VH

`define PC_BUS        31:0
`define DECODEOUT_BUS 31:0

`define PC_INITIAL    32'h0000_0000
`define NPC_INITIAL   32'h0000_0004
`define DC_INITIAL    32'h0000_0000

`define IQ_ENTRY_W    96

`endif

// File: rtl/inst_queue_ram.sv
// Entry storage for the instruction queue: two write ports, two asynchronous
// read ports, no reset (stale contents are masked by the queue count).
`include "def.vh"

module iq_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = `IQ_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  output logic [WIDTH-1:0]         rdata0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Both write ports always target different slots, so their order is irrelevant.
  always_ff @(posedge clk) begin
    if (we0) mem_q[waddr0] <= wdata0;
    if (we1) mem_q[waddr1] <= wdata1;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Two-wide in-order instruction queue between decode and launch.
// Optional feature: define IQ_BYPASS_EN to let decode outputs reach the launch
// side in the same cycle while the queue is empty.
`include "def.vh"

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             in_ready;
  logic             bypass;
  logic [1:0]       pop_req;
  logic [1:0]       n_in;
  logic [1:0]       avail;
  logic [1:0]       pop_cnt;
  logic [1:0]       push_cnt;
  logic             we0, we1;
  iq_entry_t        in1_entry, in2_entry, first_entry;
  iq_entry_t        wr_data0, wr_data1;
  iq_entry_t        rd_data0, rd_data1;
  iq_entry_t        out1_entry, out2_entry;
  logic             flag1, flag2;

  // Room for a full two-wide group, judged on the registered count only.
  assign in_ready = count_q <= CNT_W'(DEPTH - 2);

  // Work out how many entries enter and leave this cycle and what gets written.
  always_comb begin
    in1_entry   = '{pc: bus.in1_pc, npc: bus.in1_npc, dc: bus.in1_decodeout};
    in2_entry   = '{pc: bus.in2_pc, npc: bus.in2_npc, dc: bus.in2_decodeout};
    first_entry = bus.in1_valid ? in1_entry : in2_entry;
    n_in        = in_ready ? (2'(bus.in1_valid) + 2'(bus.in2_valid)) : 2'd0;
    pop_req     = pop_request(bus.launch_flag);
`ifdef IQ_BYPASS_EN
    bypass      = (count_q == '0) && !bus.flush;
`else
    bypass      = 1'b0;
`endif
    if (bypass) begin
      avail = n_in;
    end else if (count_q >= CNT_W'(2)) begin
      avail = 2'd2;
    end else begin
      avail = 2'(count_q);
    end
    pop_cnt  = (pop_req > avail) ? avail : pop_req;
    push_cnt = bypass ? (n_in - pop_cnt) : n_in;
    wr_data0 = (bypass && pop_cnt != 2'd0) ? in2_entry : first_entry;
    wr_data1 = in2_entry;
    we0      = (push_cnt != 2'd0) && !bus.flush;
    we1      = (push_cnt == 2'd2) && !bus.flush;
  end

  // Next pointer/count; a flush wins over everything else in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (bypass) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      count_d  = CNT_W'(push_cnt);
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  // Queue bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (`IQ_ENTRY_W)
  ) u_iq_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (wr_ptr_q),
    .wdata0 (wr_data0),
    .we1    (we1),
    .waddr1 (wr_ptr_q + PTR_W'(1)),
    .wdata1 (wr_data1),
    .raddr0 (rd_ptr_q),
    .rdata0 (rd_data0),
    .raddr1 (rd_ptr_q + PTR_W'(1)),
    .rdata1 (rd_data1)
  );

  // Present the two oldest entries, idle values where a slot is empty.
  always_comb begin
    flag1      = count_q >= CNT_W'(1);
    flag2      = count_q >= CNT_W'(2);
    out1_entry = flag1 ? rd_data0 : ENTRY_INIT;
    out2_entry = flag2 ? rd_data1 : ENTRY_INIT;
`ifdef IQ_BYPASS_EN
    if (bypass) begin
      flag1      = n_in != 2'd0;
      flag2      = n_in == 2'd2;
      out1_entry = flag1 ? first_entry : ENTRY_INIT;
      out2_entry = flag2 ? in2_entry : ENTRY_INIT;
    end
`endif
  end

  assign bus.in_ready       = in_ready;
  assign bus.occupancy      = count_q;
  assign bus.receive_flag1  = flag1;
  assign bus.receive_flag2  = flag2;
  assign bus.out1_pc        = out1_entry.pc;
  assign bus.out1_npc       = out1_entry.npc;
  assign bus.out1_decodeout = out1_entry.dc;
  assign bus.out2_pc        = out2_entry.pc;
  assign bus.out2_npc       = out2_entry.npc;
  assign bus.out2_decodeout = out2_entry.dc;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (default build, IQ_BYPASS_EN undefined).
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iq_entry_t model[$];

  inst_queue_if #(.DEPTH(DEPTH)) iq_bus ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (iq_bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic iq_entry_t mkEntry(input pc_t pc);
    iq_entry_t e;
    e.pc  = pc;
    e.npc = pc + 32'd4;
    e.dc  = pc ^ 32'hDEC0_0000;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of decode/launch activity, then return at the next falling edge.
  task automatic applyStimulus(input logic v1, input pc_t pc1, input logic v2, input pc_t pc2,
                               input logic [3:0] lf, input logic fl);
    iq_entry_t e1, e2;
    e1 = mkEntry(pc1);
    e2 = mkEntry(pc2);
    iq_bus.in1_valid     = v1;
    iq_bus.in1_pc        = e1.pc;
    iq_bus.in1_npc       = e1.npc;
    iq_bus.in1_decodeout = e1.dc;
    iq_bus.in2_valid     = v2;
    iq_bus.in2_pc        = e2.pc;
    iq_bus.in2_npc       = e2.npc;
    iq_bus.in2_decodeout = e2.dc;
    iq_bus.launch_flag   = lf;
    iq_bus.flush         = fl;
    @(posedge clk);
    #1;
    iq_bus.in1_valid   = 1'b0;
    iq_bus.in2_valid   = 1'b0;
    iq_bus.launch_flag = 4'b0000;
    iq_bus.flush       = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: update the expected queue on each rising edge, compare on each falling edge.
  initial begin : monitor
    iq_entry_t exp1, exp2;
    int pops;
    forever begin
      @(posedge clk);
      if (rst || iq_bus.flush) begin
        model.delete();
      end else begin
        pops = 0;
        if (iq_bus.launch_flag[3] | iq_bus.launch_flag[2])
          pops = (iq_bus.launch_flag[1] | iq_bus.launch_flag[0]) ? 2 : 1;
        if (model.size() <= DEPTH - 2) begin
          if (iq_bus.in1_valid) model.push_back(mkEntry(iq_bus.in1_pc));
          if (iq_bus.in2_valid) model.push_back(mkEntry(iq_bus.in2_pc));
        end
        for (int k = 0; k < pops; k++) begin
          if (model.size() > 0) void'(model.pop_front());
        end
      end
      @(negedge clk);
      if (rst) model.delete();
      exp1 = (model.size() >= 1) ? model[0] : ENTRY_INIT;
      exp2 = (model.size() >= 2) ? model[1] : ENTRY_INIT;
      checkOutput("mon_flag1", 128'(iq_bus.receive_flag1), 128'(model.size() >= 1));
      checkOutput("mon_flag2", 128'(iq_bus.receive_flag2), 128'(model.size() >= 2));
      checkOutput("mon_occupancy", 128'(iq_bus.occupancy), 128'(model.size()));
      checkOutput("mon_in_ready", 128'(iq_bus.in_ready), 128'(model.size() <= DEPTH - 2));
      checkOutput("mon_out1", 128'({iq_bus.out1_pc, iq_bus.out1_npc, iq_bus.out1_decodeout}), 128'(exp1));
      checkOutput("mon_out2", 128'({iq_bus.out2_pc, iq_bus.out2_npc, iq_bus.out2_decodeout}), 128'(exp2));
    end
  end

  // Hard stop in case the run ever stalls.
  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin : stimulus
    checks = 0;
    errors = 0;
    rst = 1'b1;
    iq_bus.in1_valid = 1'b0;     iq_bus.in2_valid = 1'b0;
    iq_bus.in1_pc = '0;          iq_bus.in2_pc = '0;
    iq_bus.in1_npc = '0;         iq_bus.in2_npc = '0;
    iq_bus.in1_decodeout = '0;   iq_bus.in2_decodeout = '0;
    iq_bus.launch_flag = 4'b0000;
    iq_bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_flag1", 128'(iq_bus.receive_flag1), 128'(0));
    checkOutput("rst_flag2", 128'(iq_bus.receive_flag2), 128'(0));
    checkOutput("rst_in_ready", 128'(iq_bus.in_ready), 128'(1));
    checkOutput("rst_occupancy", 128'(iq_bus.occupancy), 128'(0));
    rst = 1'b0;

    applyStimulus(1'b1, 32'h100, 1'b1, 32'h104, 4'b0000, 1'b0);
    checkOutput("push2_flag1", 128'(iq_bus.receive_flag1), 128'(1));
    checkOutput("push2_flag2", 128'(iq_bus.receive_flag2), 128'(1));
    checkOutput("push2_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h100));
    checkOutput("push2_out2_pc", 128'(iq_bus.out2_pc), 128'(32'h104));

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b1000, 1'b0);
    checkOutput("pop1_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h104));
    checkOutput("pop1_flag2", 128'(iq_bus.receive_flag2), 128'(0));
    checkOutput("pop1_occupancy", 128'(iq_bus.occupancy), 128'(1));

    applyStimulus(1'b1, 32'h108, 1'b0, 32'h0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b0001, 1'b0);
    checkOutput("inst2only_occupancy", 128'(iq_bus.occupancy), 128'(2));
    checkOutput("inst2only_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h104));

    applyStimulus(1'b1, 32'h10C, 1'b1, 32'h110, 4'b0000, 1'b0);
    applyStimulus(1'b1, 32'h114, 1'b1, 32'h118, 4'b0000, 1'b0);
    checkOutput("count6_in_ready", 128'(iq_bus.in_ready), 128'(1));
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h11C, 4'b0000, 1'b0);
    checkOutput("count7_in_ready", 128'(iq_bus.in_ready), 128'(0));
    checkOutput("count7_occupancy", 128'(iq_bus.occupancy), 128'(7));
    applyStimulus(1'b1, 32'h120, 1'b1, 32'h124, 4'b0000, 1'b0);
    checkOutput("full_push_ignored", 128'(iq_bus.occupancy), 128'(7));

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b1010, 1'b0);
    checkOutput("pop2_occupancy", 128'(iq_bus.occupancy), 128'(5));
    checkOutput("pop2_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h10C));

    applyStimulus(1'b1, 32'h130, 1'b1, 32'h134, 4'b1001, 1'b1);
    checkOutput("flush_occupancy", 128'(iq_bus.occupancy), 128'(0));
    checkOutput("flush_flag1", 128'(iq_bus.receive_flag1), 128'(0));
    checkOutput("flush_out1_npc", 128'(iq_bus.out1_npc), 128'(32'h4));

    applyStimulus(1'b1, 32'h140, 1'b0, 32'h0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'b0101, 1'b0);
    checkOutput("overpop_occupancy", 128'(iq_bus.occupancy), 128'(0));
    checkOutput("overpop_flag1", 128'(iq_bus.receive_flag1), 128'(0));

    applyStimulus(1'b1, 32'h200, 1'b1, 32'h204, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h208 + 32'(8 * i), 1'b1, 32'h20C + 32'(8 * i), 4'b1010, 1'b0);
    end
    checkOutput("wrap_occupancy", 128'(iq_bus.occupancy), 128'(2));
    checkOutput("wrap_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h2A0));
    checkOutput("wrap_out2_pc", 128'(iq_bus.out2_pc), 128'(32'h2A4));

    applyStimulus(1'b1, 32'h300, 1'b1, 32'h304, 4'b0000, 1'b0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_occupancy", 128'(iq_bus.occupancy), 128'(0));
    checkOutput("midrst_flag1", 128'(iq_bus.receive_flag1), 128'(0));
    rst = 1'b0;
    applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 4'b0000, 1'b0);
    checkOutput("postrst_out1_pc", 128'(iq_bus.out1_pc), 128'(32'h400));
    checkOutput("postrst_occupancy", 128'(iq_bus.occupancy), 128'(1));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
